// File: rtl/alu_arb_pkg.sv
// Shared widths and FSM state type for the two-requester ALU arbiter.
package alu_arb_pkg;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;
    localparam int NREQ   = 2;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;
endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes
// to the requester that was not served last.
module rr_pick2
    import alu_arb_pkg::*;
(
    input  logic [NREQ-1:0] valid_i,
    input  logic            last_i,
    output logic [NREQ-1:0] grant_o
);
    always_comb begin
        grant_o = '0;
        unique case (1'b1)
            (valid_i == 2'b11): grant_o = last_i ? 2'b01 : 2'b10;
            default:            grant_o = valid_i;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external registered ALU between two requesters, one
// operation in flight, result held until the winner consumes it.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*DATA_W-1:0]  req_a,
    input  logic [2*DATA_W-1:0]  req_b,
    input  logic [2*SEL_W-1:0]   req_sel,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [DATA_W-1:0]    rsp_data,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [SEL_W-1:0]     alu_sel,
    input  logic [DATA_W-1:0]    alu_out,
    output logic                 busy
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               win_q, win_d;
    logic               last_q, last_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [NREQ-1:0]    grant;

    rr_pick2 u_pick (
        .valid_i (req_valid),
        .last_i  (last_q),
        .grant_o (grant)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        last_d    = last_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        data_d    = data_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                // Gated by rst_n so nothing looks accepted while held in reset
                req_ready = rst_n ? grant : '0;
                if (|grant) begin
                    win_d   = grant[1];
                    a_d     = grant[1] ? req_a[15:8] : req_a[7:0];
                    b_d     = grant[1] ? req_b[15:8] : req_b[7:0];
                    sel_d   = grant[1] ? req_sel[7:4] : req_sel[3:0];
                    cnt_d   = CNT_W'(ALU_LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    data_d  = alu_out;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready[win_q]) begin
                    last_d  = win_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign rsp_valid = (state_q == RESP) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = data_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter ALU_LATENCY, default 1: clock edges from ALU operand update to valid ALU_out (1..7).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, 2 bits: bit i = requester i has an operation pending.
REQ-005 The block SHALL have port req_ready, output, 2 bits: bit i = operation of requester i accepted this cycle.
REQ-006 The block SHALL have port req_a, input, 16 bits: operand A, requester i in bits [8i+7:8i].
REQ-007 The block SHALL have port req_b, input, 16 bits: operand B, same packing as req_a.
REQ-008 The block SHALL have port req_sel, input, 8 bits: 4-bit ALU select, requester i in bits [4i+3:4i].
REQ-009 The block SHALL have port rsp_valid, output, 2 bits: bit i = result for requester i is held on rsp_data.
REQ-010 The block SHALL have port rsp_ready, input, 2 bits: bit i = requester i consumes its result.
REQ-011 The block SHALL have port rsp_data, output, 8 bits: captured ALU result.
REQ-012 The block SHALL have port alu_a, output, 8 bits: ALU operand A, registered.
REQ-013 The block SHALL have port alu_b, output, 8 bits: ALU operand B, registered.
REQ-014 The block SHALL have port alu_sel, output, 4 bits: ALU select, registered, passed through without decoding.
REQ-015 The block SHALL have port alu_out, input, 8 bits: registered ALU result.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, WAIT and RESP; one operation is in flight at a time.
REQ-018 In IDLE, req_ready SHALL be combinational and one-hot for the granted requester with req_valid high; it SHALL be zero in WAIT and RESP.
REQ-019 Arbitration SHALL be round-robin: if both requesters are valid, grant goes to the one not served last; if one is valid, it is granted regardless of the pointer.
REQ-020 On the accept edge (E0), the block SHALL latch alu_a, alu_b and alu_sel from the winner, record the winner index, load the wait counter with ALU_LATENCY, and enter WAIT.
REQ-021 In WAIT, the counter SHALL decrement each edge; at edge E0+ALU_LATENCY+1 the block SHALL capture alu_out into rsp_data and enter RESP, raising rsp_valid[winner] only.
REQ-022 With ALU_LATENCY=1, rsp_valid SHALL rise exactly 2 cycles after the accept edge.
REQ-023 In RESP, rsp_valid and rsp_data SHALL hold stable until rsp_ready[winner] is high; on that edge the FSM SHALL return to IDLE, clear rsp_valid and update the last-served pointer to the winner.
REQ-024 If rsp_ready is already high on entry to RESP, RESP SHALL last exactly one cycle.
REQ-025 rsp_ready of the non-winning requester SHALL be ignored.
REQ-026 A new accept SHALL be possible in the first IDLE cycle after RESP, giving back-to-back throughput of one operation per ALU_LATENCY+3 cycles.
REQ-027 alu_a, alu_b and alu_sel SHALL hold their last values outside the accept edge.
REQ-028 req_valid dropping while not granted SHALL have no effect; the block SHALL not require valid to be held.

Reset
REQ-029 While rst_n is low, the block SHALL be in IDLE, with rsp_valid=0, rsp_data=0, alu_a=0, alu_b=0, alu_sel=0, busy=0, counter=0, and the pointer set so requester 0 wins the first tie.
REQ-030 Reset asserted mid-WAIT or mid-RESP SHALL discard the in-flight operation; no rsp_valid SHALL follow deassertion.

Structure
REQ-031 Package alu_arb_pkg SHALL hold DATA_W=8, SEL_W=4, NREQ=2 and the state enum {IDLE, WAIT, RESP}.
REQ-032 The block SHALL contain one sub-module, rr_pick2, as combinational grant logic from req_valid plus the last-served pointer; the ALU itself SHALL stay outside the block.

Verification
REQ-033 The bench SHALL cover these scenarios, with the team ALU attached (sel 4'h0 = A+B, 4'h1 = A-B):
- After reset, req0 valid with A=5, B=1, sel=0 and rsp_ready=1 -> req_ready=01 for one cycle; rsp_valid=01 and rsp_data=6 two cycles later; RESP lasts one cycle.
- Both requesters valid from reset (req0 5+1, req1 A=9, B=4, sel=1), rsp_ready=11 -> req0 is served first (6), then req1 (5), then req0 again.
- rsp_ready held low 5 cycles in RESP -> rsp_data stays stable and req_ready stays 00 throughout.
- rst_n pulsed low during WAIT -> all outputs go to zero at once and no rsp_valid follows.
- ALU_LATENCY=3 build, single request -> rsp_valid rises 4 cycles after accept.
